// File: rtl/cache_ctrl.sv
// cache_ctrl: controller for a single cache set array.
// It takes single-word CPU reads and writes and turns them into set commands
// (enable/comp/write). On a miss it writes back a dirty victim block, refills
// the four words from a word-wide memory port, and then retries the compare.
//
// Ports
//   clk, rst               : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata  : CPU request; accepted when cpu_req & cpu_ready
//   cpu_ready              : high only while idle and out of reset
//   cpu_done               : one-cycle completion pulse
//   cpu_rdata, cpu_hit     : read data and first-compare hit, valid with cpu_done
//   set_en/comp/write/...  : command to the set array, held until set_ack
//   set_hit/dirty/...      : set array response, sampled with set_ack
//   mem_req/we/addr/wdata  : memory request, held until mem_ack
//   mem_rdata, mem_ack     : memory response
module cache_ctrl #(
    parameter int IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [IDX_W+6:0]     cpu_addr,
    input  logic [15:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    output logic [15:0]          cpu_rdata,
    output logic                 cpu_hit,
    output logic                 set_en,
    output logic                 set_comp,
    output logic                 set_write,
    output logic [IDX_W-1:0]     set_index,
    output logic [1:0]           set_word,
    output logic [4:0]           set_tag,
    output logic [15:0]          set_data,
    output logic                 set_valid,
    input  logic                 set_hit,
    input  logic                 set_dirty,
    input  logic                 set_valid_out,
    input  logic                 set_ack,
    input  logic [4:0]           set_tag_out,
    input  logic [15:0]          set_data_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [IDX_W+6:0]     mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_ack
);
    localparam int AW = IDX_W + 7;

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_PROBE, S_WB_RD, S_WB_MEM, S_RF_MEM, S_RF_WR, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic            set_en_q, set_en_d;
    logic            mem_req_q, mem_req_d;
    logic            first_q, first_d;
    logic            hit_q, hit_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [4:0]      victim_q, victim_d;
    logic [15:0]     buf_q, buf_d;      // word in flight: writeback or refill

    logic [4:0]       req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_word;
    logic             set_fire, set_issue, mem_fire, hit;

    assign req_tag  = addr_q[AW-1 -: 5];
    assign req_idx  = addr_q[IDX_W+1:2];
    assign req_word = addr_q[1:0];

    assign set_fire  = set_en_q & set_ack;
    // A new set command may only start once the previous ack has been seen low.
    assign set_issue = ~set_en_q & ~set_ack;
    assign mem_fire  = mem_req_q & mem_ack;
    assign hit       = set_hit & set_valid_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            set_en_q  <= 1'b0;
            mem_req_q <= 1'b0;
            first_q   <= 1'b0;
            hit_q     <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            set_en_q  <= set_en_d;
            mem_req_q <= mem_req_d;
            first_q   <= first_d;
            hit_q     <= hit_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        victim_q <= victim_d;
        buf_q    <= buf_d;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        set_en_d  = set_en_q;
        mem_req_d = mem_req_q;
        first_d   = first_q;
        hit_d     = hit_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        victim_d  = victim_q;
        buf_d     = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    first_d  = 1'b1;
                    // Launch the compare on the accept edge when the set is quiet.
                    set_en_d = ~set_ack;
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                if (set_fire) begin
                    set_en_d = 1'b0;
                    first_d  = 1'b0;
                    if (first_q) hit_d = hit;
                    if (hit) begin
                        if (!we_q) rdata_d = set_data_out;
                        state_d = S_DONE;
                    end else if (set_valid_out && set_dirty) begin
                        state_d = S_PROBE;
                    end else begin
                        k_d     = 2'd0;
                        state_d = S_RF_MEM;
                    end
                end else if (set_issue) begin
                    set_en_d = 1'b1;
                end
            end
            S_PROBE: begin
                if (set_fire) begin
                    set_en_d = 1'b0;
                    victim_d = set_tag_out;
                    k_d      = 2'd0;
                    state_d  = S_WB_RD;
                end else if (set_issue) begin
                    set_en_d = 1'b1;
                end
            end
            S_WB_RD: begin
                if (set_fire) begin
                    set_en_d = 1'b0;
                    buf_d    = set_data_out;
                    state_d  = S_WB_MEM;
                end else if (set_issue) begin
                    set_en_d = 1'b1;
                end
            end
            S_WB_MEM: begin
                if (mem_fire) begin
                    mem_req_d = 1'b0;
                    k_d       = 2'(k_q + 2'd1);
                    state_d   = (k_q == 2'd3) ? S_RF_MEM : S_WB_RD;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            S_RF_MEM: begin
                if (mem_fire) begin
                    mem_req_d = 1'b0;
                    buf_d     = mem_rdata;
                    state_d   = S_RF_WR;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            S_RF_WR: begin
                if (set_fire) begin
                    set_en_d = 1'b0;
                    k_d      = 2'(k_q + 2'd1);
                    state_d  = (k_q == 2'd3) ? S_CMP : S_RF_MEM;
                end else if (set_issue) begin
                    set_en_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are pure functions of state and latched registers, so they
    // stay constant for as long as a handshake is outstanding.
    always_comb begin
        set_comp  = 1'b0;
        set_write = 1'b0;
        set_index = '0;
        set_word  = 2'd0;
        set_tag   = 5'd0;
        set_data  = 16'd0;
        set_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'd0;
        unique case (state_q)
            S_CMP: begin
                set_comp  = 1'b1;
                set_write = we_q;
                set_index = req_idx;
                set_word  = req_word;
                set_tag   = req_tag;
                set_data  = wdata_q;
                set_valid = 1'b1;
            end
            S_PROBE: begin
                set_index = req_idx;
                set_tag   = req_tag;
            end
            S_WB_RD: begin
                set_comp  = 1'b1;
                set_index = req_idx;
                set_word  = k_q;
                set_tag   = victim_q;
            end
            S_WB_MEM: begin
                mem_we    = mem_req_q;
                mem_addr  = {victim_q, req_idx, k_q};
                mem_wdata = buf_q;
            end
            S_RF_MEM: mem_addr = {req_tag, req_idx, k_q};
            S_RF_WR: begin
                set_write = 1'b1;
                set_index = req_idx;
                set_word  = k_q;
                set_tag   = req_tag;
                set_data  = buf_q;
                set_valid = (k_q == 2'd3);
            end
            default: ;
        endcase
    end

    assign cpu_ready = (state_q == S_IDLE) & ~rst;
    assign cpu_done  = (state_q == S_DONE);
    assign cpu_rdata = rdata_q;
    assign cpu_hit   = hit_q;
    assign set_en    = set_en_q;
    assign mem_req   = mem_req_q;
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Synchronous cache controller sitting directly upstream of the cache set array. Accepts single-word CPU read/write requests and drives the set's enable/comp/write command interface. On a miss it performs dirty-block writeback and 4-word refill against a word-wide memory port, then retries the compare. It owns all sequencing; the set only executes one command per enable pulse.

## Interface
- IDX_W, 3, set index width; cpu_addr width = 5 + IDX_W + 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  request valid; accepted when cpu_req & cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  7+IDX_W  {tag[4:0], index[IDX_W-1:0], word[1:0]}
- cpu_wdata  in  16  write data
- cpu_ready  out  1  high only in IDLE
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid with cpu_done, held until next done
- cpu_hit  out  1  result of first compare, valid with cpu_done
- set_en, set_comp, set_write  out  1 each  set command
- set_index  out  IDX_W  selected set
- set_word  out  2; set_tag  out  5; set_data  out  16; set_valid  out  1
- set_hit, set_dirty, set_valid_out, set_ack  in  1 each; set_tag_out  in  5; set_data_out  in  16
- mem_req, mem_we  out  1 each; mem_addr  out  7+IDX_W; mem_wdata  out  16
- mem_rdata  in  16; mem_ack  in  1

## Operation
- States: IDLE, CMP, PROBE, WB_RD, WB_MEM, RF_MEM, RF_WR, DONE. 2-bit word counter k.
- IDLE: on accept latch we/addr/wdata -> CMP.
- CMP: compare op (comp=1, write=we, tag/word from request, data=wdata). On ack: hit = set_hit & set_valid_out. Hit -> DONE (read: latch set_data_out). Miss & set_valid_out & set_dirty -> PROBE. Other miss -> RF_MEM, k=0. cpu_hit latched only on first compare of a request.
- PROBE: access read (comp=0, write=0); latch set_tag_out as victim tag -> WB_RD, k=0.
- WB_RD: compare read with victim tag, word k; latch set_data_out -> WB_MEM.
- WB_MEM: mem write, addr {victim, index, k}. On ack: k==3 -> RF_MEM k=0, else k+1 -> WB_RD.
- RF_MEM: mem read {req tag, index, k}; latch mem_rdata on ack -> RF_WR.
- RF_WR: access write (comp=0, write=1), word k, req tag, data = latched word, set_valid = (k==3). On ack: k==3 -> CMP (retry, guaranteed hit), else k+1 -> RF_MEM.
- DONE: cpu_done=1 one cycle -> IDLE.
- Set handshake: set_en and all set_* inputs held constant until set_ack sampled high; set_en low next cycle; next command only after set_en low ≥1 cycle and set_ack sampled low.
- Memory handshake: mem_req/mem_we/mem_addr/mem_wdata held until mem_ack; mem_req low ≥1 cycle between transactions.
- Ignored: cpu_req when not ready, set_ack while set_en low, mem_ack while mem_req low.

## Timing
- Reset values: cpu_ready=0 during rst, 1 first cycle after; all other outputs 0; state IDLE, k=0.
- rst mid-operation: next edge drops set_en/mem_req, aborts request, no cpu_done; set contents untouched.
- Hit latency: accept at cycle 0, set_en high cycle 1, ack sampled cycle a, cpu_done at a+1.
- Clean miss: 1 compare + 4×(mem read + access write) + retry compare.
- Dirty miss adds 1 probe + 4×(compare read + mem write) before refill.
- Write hit leaves block dirty (set handles); refill leaves block clean then retry write sets dirty.
- cpu_ready low from cycle after accept through DONE.

## Test plan
- Cold read 0x0A5 (tag 5, idx 1, word 1), memory word = addr: cpu_hit=0, 4 mem reads 0x0A4–0x0A7, 4 access writes with set_valid 0,0,0,1, retry compare, cpu_rdata=0x00A5.
- Repeat read 0x0A5: cpu_hit=1, no mem_req, cpu_done exactly 2 cycles after set_en with 1-cycle set ack.
- Write 0x0A6 data 0xBEEF (hit), then read 0x1A6 (tag 13, same idx): probe returns tag 5 dirty; mem writes to 0x0A4–0x0A7 with 0xBEEF at 0x0A6; refill 0x1A4–0x1A7.
- Stall set_ack 5 cycles and mem_ack 3 cycles: set_* and mem_* outputs stable throughout; set_en low ≥1 cycle between commands.
- Assert rst during WB_MEM with mem_req high: next cycle mem_req=0, set_en=0, cpu_done never pulses, cpu_ready=1 after rst drops.
- cpu_req held high during miss: second request accepted only after cpu_done, exactly once.
